mixed_chan_buffer: RTL

MIXED_CHAN_BUFFER -- requirements
Module: mixed_chan_buffer

---
 rtl/mixed_chan_buffer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mixed_chan_buffer.sv
// mixed_chan_buffer: multi-channel FIFO buffer sharing one dual-port memory.
// Each channel owns a DEPTH-word region addressed as {chan, ptr}. An arbiter
// picks a non-empty channel to read, read data lands in a 2-entry output skid
// FIFO, and the skid head drives the egress.
//
// Handshakes: a beat transfers on a rising edge where valid && ready are both
// high. A producer holds valid and its payload until that edge; the consumer
// may toggle ready freely. Here in_rdy depends combinationally on in_chan,
// while out_vld/out_data/out_chan are registered and stay put while stalled.
module mixed_chan_buffer #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 16,
   parameter int NCH      = 2,
   parameter int ARB_MODE = 0,
   localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CW-1:0]     in_chan,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic [CW-1:0]     out_chan,
   input  logic [CW-1:0]     stat_chan,
   output logic [AW:0]       stat_count,
   output logic              stat_stall,
   input  logic              stat_clr
);

   localparam int MAW = $clog2(NCH * DEPTH);

   // Word address of a channel slot; for a single channel the tag bit drops out.
   function automatic logic [MAW-1:0] word_addr(input logic [CW-1:0] chan,
                                                input logic [AW-1:0] ptr);
      return MAW'({chan, ptr});
   endfunction

   logic [DATA_W-1:0] mem [NCH*DEPTH];

   logic [AW-1:0]     wptr [NCH];
   logic [AW-1:0]     rptr [NCH];
   logic [AW:0]       cnt  [NCH];
   logic [NCH-1:0]    sticky;
   logic [CW-1:0]     last_gnt;

   logic              gnt_vld;
   logic [CW-1:0]     gnt_chan;
   logic              rd_issue;
   logic              wr_en;
   logic [NCH-1:0]    wr_hit;
   logic [NCH-1:0]    rd_hit;
   logic [NCH-1:0]    stall_hit;
   logic [NCH-1:0]    clr_hit;

   logic              rd_vld;
   logic [CW-1:0]     rd_chan;
   logic [DATA_W-1:0] rd_data;

   logic [DATA_W-1:0] sk_data [2];
   logic [CW-1:0]     sk_chan [2];
   logic              sk_head;
   logic              sk_tail;
   logic [1:0]        sk_cnt;
   logic              sk_pop;
   logic [2:0]        occ_eff;

   assign in_rdy     = (cnt[in_chan] != (AW+1)'(DEPTH));
   assign wr_en      = in_vld && in_rdy;
   assign out_vld    = (sk_cnt != 2'd0);
   assign out_data   = sk_data[sk_head];
   assign out_chan   = sk_chan[sk_head];
   assign sk_pop     = out_vld && out_rdy;
   assign stat_count = cnt[stat_chan];
   assign stat_stall = sticky[stat_chan];

   // Skid slots that will be taken once this cycle's pop and the in-flight
   // read settle; counting the pop keeps one read per cycle in steady state.
   assign occ_eff  = 3'(sk_cnt) - 3'(sk_pop) + 3'(rd_vld);
   assign rd_issue = gnt_vld && (occ_eff < 3'd2);

   // Arbiter: fixed priority picks the lowest non-empty channel; round-robin
   // searches upward from the channel after the last grant, wrapping.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_chan = '0;
      if (ARB_MODE == 1) begin
         for (int i = NCH - 1; i >= 0; i--) begin
            if (cnt[i] != '0) begin
               gnt_vld  = 1'b1;
               gnt_chan = CW'(i);
            end
         end
      end else begin
         for (int k = NCH; k >= 1; k--) begin
            if (cnt[(int'(last_gnt) + k) % NCH] != '0) begin
               gnt_vld  = 1'b1;
               gnt_chan = CW'((int'(last_gnt) + k) % NCH);
            end
         end
      end
   end

   // Per-channel decode of write, read, stall and status-clear events.
   always_comb begin
      wr_hit    = '0;
      rd_hit    = '0;
      stall_hit = '0;
      clr_hit   = '0;
      for (int c = 0; c < NCH; c++) begin
         wr_hit[c]    = wr_en && (in_chan == CW'(c));
         rd_hit[c]    = rd_issue && (gnt_chan == CW'(c));
         stall_hit[c] = in_vld && !in_rdy && (in_chan == CW'(c));
         clr_hit[c]   = stat_clr && (stat_chan == CW'(c));
      end
   end

   // Channel pointers, occupancy counts and sticky stall flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            wptr[c] <= '0;
            rptr[c] <= '0;
            cnt[c]  <= '0;
         end
         sticky <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (wr_hit[c]) wptr[c] <= wptr[c] + AW'(1);
            if (rd_hit[c]) rptr[c] <= rptr[c] + AW'(1);
            case ({wr_hit[c], rd_hit[c]})
               2'b10:   cnt[c] <= cnt[c] + (AW+1)'(1);
               2'b01:   cnt[c] <= cnt[c] - (AW+1)'(1);
               default: ;
            endcase
            // A new stall in the same cycle beats the clear.
            if (stall_hit[c])     sticky[c] <= 1'b1;
            else if (clr_hit[c])  sticky[c] <= 1'b0;
         end
      end
   end

   // Memory port A: ingress writes. Contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[word_addr(in_chan, wptr[in_chan])] <= in_data;
   end

   // Memory port B: registered read, one cycle of latency.
   always_ff @(posedge clk) begin
      if (rd_issue) rd_data <= mem[word_addr(gnt_chan, rptr[gnt_chan])];
   end

   // In-flight read tracking and round-robin grant history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld   <= 1'b0;
         rd_chan  <= '0;
         last_gnt <= CW'(NCH - 1);
      end else begin
         rd_vld <= rd_issue;
         if (rd_issue) rd_chan <= gnt_chan;
         if (rd_issue && (ARB_MODE == 0)) last_gnt <= gnt_chan;
      end
   end

   // Output skid FIFO: loads arriving read data, pops on egress handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sk_data[0] <= '0;
         sk_data[1] <= '0;
         sk_chan[0] <= '0;
         sk_chan[1] <= '0;
         sk_head    <= 1'b0;
         sk_tail    <= 1'b0;
         sk_cnt     <= 2'd0;
      end else begin
         if (rd_vld) begin
            sk_data[sk_tail] <= rd_data;
            sk_chan[sk_tail] <= rd_chan;
            sk_tail          <= ~sk_tail;
         end
         if (sk_pop) sk_head <= ~sk_head;
         sk_cnt <= sk_cnt + 2'(rd_vld) - 2'(sk_pop);
      end
   end

endmodule
